// File: rtl/wr_ptr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : wr_ptr_ctrl_if
// Description : Write-side bundle of the async FIFO pointer controller.
//               master = producer / parent side. It drives wr_en and the
//                        read Gray pointer, and it observes the status outputs.
//               slave  = wr_ptr_ctrl.
//               Signals:
//                 wr_en       producer write request
//                 rd_gptr     read-domain Gray pointer (ADDR_W+1)
//                 wr_fire     RAM write enable
//                 wr_addr     RAM write address (ADDR_W)
//                 wr_gptr     Gray write pointer to read-side sync (ADDR_W+1)
//                 full        FIFO holds DEPTH entries
//                 almost_full level at or above programmed threshold
//                 wr_level    occupancy seen from the write side (ADDR_W+1)
//                 overflow    sticky write-while-full flag
// Revision    : 1.0 - initial release
// ============================================================================
interface wr_ptr_ctrl_if #(
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [ADDR_W:0]   rd_gptr;
    logic              wr_fire;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   wr_gptr;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   wr_level;
    logic              overflow;

    modport master (
        output wr_en,
        output rd_gptr,
        input  wr_fire,
        input  wr_addr,
        input  wr_gptr,
        input  full,
        input  almost_full,
        input  wr_level,
        input  overflow
    );

    modport slave (
        input  wr_en,
        input  rd_gptr,
        output wr_fire,
        output wr_addr,
        output wr_gptr,
        output full,
        output almost_full,
        output wr_level,
        output overflow
    );
endinterface
`default_nettype wire

// File: rtl/wr_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wr_ptr_ctrl
// Description : Write-side pointer and flag controller for the async FIFO.
//               It keeps the binary and Gray write pointers and detects full
//               against the read Gray pointer. It also produces the fill
//               level, the almost-full flag and a sticky overflow flag.
// Ports       : wclk     write clock; all logic on posedge
//               wr_srst  synchronous active-high reset
//               bus      wr_ptr_ctrl_if.slave (see interface header)
// Config      : WR_PTR_SYNC_EN - when defined, rd_gptr is treated as
//               asynchronous and passes through an internal 2-flop
//               synchroniser. When undefined, rd_gptr is used directly.
// Revision    : 1.0 - initial release
// ============================================================================
module wr_ptr_ctrl #(
    parameter int ADDR_W       = 3,
    parameter int AFULL_THRESH = 2**ADDR_W - 2
) (
    input  logic           wclk,
    input  logic           wr_srst,
    wr_ptr_ctrl_if.slave   bus
);

    localparam logic [ADDR_W:0] c_AFULL = AFULL_THRESH[ADDR_W:0];

    logic [ADDR_W:0] r_bptr;
    logic [ADDR_W:0] r_gptr;
    logic [ADDR_W:0] r_level;
    logic            r_full;
    logic            r_afull;
    logic            r_ovf;

    logic            w_fire;
    logic [ADDR_W:0] w_bptr_nx;
    logic [ADDR_W:0] w_gptr_nx;
    logic [ADDR_W:0] w_rq;
    logic [ADDR_W:0] w_rbin;
    logic [ADDR_W:0] w_level_nx;
    logic            w_full_nx;
    logic            w_afull_nx;

`ifdef WR_PTR_SYNC_EN
    // Two-flop synchroniser for the read pointer from the rclk domain. Each
    // Gray step changes a single bit, so a sampled value is always either the
    // old pointer or the new pointer.
    logic [ADDR_W:0] r_sync1;
    logic [ADDR_W:0] r_sync2;

    always_ff @(posedge wclk) begin
        if (wr_srst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.rd_gptr;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rq = r_sync2;
`else
    assign w_rq = bus.rd_gptr;
`endif

    // A write in the reset cycle is ignored, so the RAM must not write then.
    assign w_fire     = bus.wr_en & ~r_full & ~wr_srst;
    assign w_bptr_nx  = r_bptr + {{ADDR_W{1'b0}}, w_fire};
    assign w_gptr_nx  = w_bptr_nx ^ (w_bptr_nx >> 1);

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_rbin = '0;
        for (int i = 0; i <= ADDR_W; i++) begin
            w_rbin[i] = ^(w_rq >> i);
        end
    end

    // Full means the write pointer is exactly one lap ahead of the read pointer.
    // In Gray code that is the read pointer with its two MSBs inverted.
    assign w_full_nx  = (w_gptr_nx == {~w_rq[ADDR_W:ADDR_W-1], w_rq[ADDR_W-2:0]});
    assign w_level_nx = w_bptr_nx - w_rbin;
    assign w_afull_nx = (w_level_nx >= c_AFULL);

    always_ff @(posedge wclk) begin
        if (wr_srst) begin
            r_bptr  <= '0;
            r_gptr  <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_bptr  <= w_bptr_nx;
            r_gptr  <= w_gptr_nx;
            r_level <= w_level_nx;
            r_full  <= w_full_nx;
            r_afull <= w_afull_nx;
            r_ovf   <= r_ovf | (bus.wr_en & r_full);
        end
    end

    assign bus.wr_fire     = w_fire;
    assign bus.wr_addr     = r_bptr[ADDR_W-1:0];
    assign bus.wr_gptr     = r_gptr;
    assign bus.full        = r_full;
    assign bus.almost_full = r_afull;
    assign bus.wr_level    = r_level;
    assign bus.overflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_wr_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wr_ptr_ctrl
// Description : Directed self-checking bench for wr_ptr_ctrl (ADDR_W=3,
//               AFULL_THRESH=6). Expected read-side latency follows
//               WR_PTR_SYNC_EN: 3 edges when defined, 1 edge otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wr_ptr_ctrl;

    localparam int c_AW = 3;
`ifdef WR_PTR_SYNC_EN
    localparam int c_LAT = 3;
`else
    localparam int c_LAT = 1;
`endif

    logic wclk;
    logic wr_srst;
    int   total;
    int   bad;

    wr_ptr_ctrl_if #(.ADDR_W(c_AW)) bus ();

    wr_ptr_ctrl #(
        .ADDR_W       (c_AW),
        .AFULL_THRESH (6)
    ) u_dut (
        .wclk    (wclk),
        .wr_srst (wr_srst),
        .bus     (bus)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] gray(input int b);
        logic [3:0] v;
        v = b[3:0];
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge; inputs and outputs are then handled 1 time unit later.
    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_fire"},  32'(bus.wr_fire),     0);
        chk({tag, "_addr"},  32'(bus.wr_addr),     0);
        chk({tag, "_gptr"},  32'(bus.wr_gptr),     0);
        chk({tag, "_full"},  32'(bus.full),        0);
        chk({tag, "_afull"}, 32'(bus.almost_full), 0);
        chk({tag, "_level"}, 32'(bus.wr_level),    0);
        chk({tag, "_ovf"},   32'(bus.overflow),    0);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        wr_srst     = 1'b1;
        bus.wr_en   = 1'b1;
        bus.rd_gptr = '0;
        step();
        step();
        wr_srst   = 1'b0;
        bus.wr_en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk_zero("reset_idle");

        // Fill from empty: eight writes.
        for (int i = 0; i < 8; i++) begin
            bus.wr_en = 1'b1;
            #1;
            chk("fill_fire", 32'(bus.wr_fire), 1);
            chk("fill_addr", 32'(bus.wr_addr), 32'(i));
            step();
            chk("fill_gptr",  32'(bus.wr_gptr),     32'(gray(i + 1)));
            chk("fill_level", 32'(bus.wr_level),    32'(i + 1));
            chk("fill_afull", 32'(bus.almost_full), 32'((i + 1) >= 6));
            chk("fill_full",  32'(bus.full),        32'(i == 7));
        end

        // Two writes while full are rejected and set overflow.
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("ovf_fire", 32'(bus.wr_fire), 0);
            step();
            chk("ovf_gptr",  32'(bus.wr_gptr),  12);
            chk("ovf_addr",  32'(bus.wr_addr),  0);
            chk("ovf_level", 32'(bus.wr_level), 8);
            chk("ovf_flag",  32'(bus.overflow), 1);
        end

        // Read side reports three entries consumed (Gray(3)=2).
        bus.wr_en   = 1'b0;
        bus.rd_gptr = 4'd2;
        for (int k = 1; k <= c_LAT; k++) begin
            step();
            chk("rd_full",  32'(bus.full),        32'(k < c_LAT));
            chk("rd_level", 32'(bus.wr_level),    (k < c_LAT) ? 8 : 5);
            chk("rd_afull", 32'(bus.almost_full), 32'(k < c_LAT));
            chk("rd_ovf",   32'(bus.overflow),    1);
        end

        bus.wr_en = 1'b1;
        step();
        bus.wr_en = 1'b0;
        chk("w9_level", 32'(bus.wr_level),    6);
        chk("w9_afull", 32'(bus.almost_full), 1);
        chk("w9_gptr",  32'(bus.wr_gptr),     13);
        chk("w9_addr",  32'(bus.wr_addr),     1);
        chk("w9_ovf",   32'(bus.overflow),    1);

        // Reset clears everything, including the sticky overflow.
        wr_srst     = 1'b1;
        bus.rd_gptr = '0;
        step();
        wr_srst = 1'b0;
        chk_zero("reset2");

        // Lockstep write/read for 40 entries; pointer wraps 15 -> 0 twice.
        for (int i = 0; i < 40; i++) begin
            bus.rd_gptr = gray(i % 16);
            bus.wr_en   = 1'b1;
            step();
            chk("wrap_gptr",  32'(bus.wr_gptr), 32'(gray((i + 1) % 16)));
            chk("wrap_addr",  32'(bus.wr_addr), 32'((i + 1) % 8));
            chk("wrap_full",  32'(bus.full),    0);
            chk("wrap_level", 32'(bus.wr_level <= 4'(c_LAT)), 1);
        end

        // Reset in the middle of a burst.
        for (int i = 0; i < 3; i++) step();
        wr_srst = 1'b1;
        step();
        wr_srst     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_gptr = '0;
        #1;
        chk_zero("midburst_rst");
        step();
        chk_zero("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
